// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: MEM register, data-memory handshake FSM with wait
// timeout, and the WB register that feeds the register file and forwarding.
module mem_wb_stage #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [4:0]        ex_dst,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] mem_wb_data,
    output logic [4:0]        mem_wb_dst,
    output logic              mem_wb_we,
    output logic              mem_err
);

    localparam int unsigned REG_W = 5;
    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic [REG_W-1:0]  dst;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] sdata;
    } mem_entry_t;

    typedef struct packed {
        logic              we;
        logic [REG_W-1:0]  dst;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    state_t            state_q;
    state_t            state_d;
    mem_entry_t        mem_q;
    mem_entry_t        ex_entry;
    wb_entry_t         wb_q;
    wb_entry_t         wb_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              err_q;
    logic              abort;
    logic              ex_mem_op;

    assign ex_mem_op = ex_valid && (ex_mem_read || ex_mem_write);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin : fsm_reg
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, memory handshake, stall and wait-counter update
    always_comb begin : fsm_comb
        state_d = state_q;
        stall   = 1'b0;
        mem_req = 1'b0;
        mem_we  = 1'b0;
        abort   = 1'b0;
        cnt_d   = '0;
        case (state_q)
            IDLE: begin
                if (ex_mem_op) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                mem_req = 1'b1;
                mem_we  = mem_q.mem_write;
                if (mem_ready) begin
                    state_d = ex_mem_op ? ACCESS : IDLE;
                end else begin
                    stall = 1'b1;
                    // The last permitted wait cycle aborts on its closing edge
                    if (cnt_q == CNT_LAST) begin
                        abort   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Incoming instruction as a MEM entry
    always_comb begin : ex_pack
        ex_entry           = '0;
        ex_entry.valid     = 1'b1;
        ex_entry.reg_write = ex_reg_write;
        ex_entry.mem_read  = ex_mem_read;
        ex_entry.mem_write = ex_mem_write;
        ex_entry.dst       = ex_dst;
        ex_entry.alu       = ex_alu_result;
        ex_entry.sdata     = ex_store_data;
    end

    // Writeback candidate; r0 and non-writing entries collapse to all-zero
    always_comb begin : wb_next
        wb_d = '0;
        if (mem_q.valid && mem_q.reg_write && !mem_q.mem_write && (mem_q.dst != '0)) begin
            wb_d.we   = 1'b1;
            wb_d.dst  = mem_q.dst;
            wb_d.data = mem_q.mem_read ? mem_rdata : mem_q.alu;
        end
    end

    // MEM and WB registers, wait counter and sticky error
    always_ff @(posedge clk or negedge rst_n) begin : pipe_regs
        if (!rst_n) begin
            mem_q <= '0;
            wb_q  <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (abort) begin
                mem_q <= '0;
                wb_q  <= '0;
                err_q <= 1'b1;
            end else if (!stall) begin
                mem_q <= ex_valid ? ex_entry : '0;
                wb_q  <= wb_d;
            end
        end
    end

    assign mem_addr    = {mem_q.alu[DATA_W-1:2], 2'b00};
    assign mem_wdata   = mem_q.sdata;
    assign mem_wb_we   = wb_q.we;
    assign mem_wb_dst  = wb_q.dst;
    assign mem_wb_data = wb_q.data;
    assign mem_err     = err_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed scenarios then a random instruction stream,
// all checked against a two-slot behavioural model of the stage.
module tb_mem_wb_stage;

    localparam int unsigned DATA_W  = 32;
    localparam int          TIMEOUT = 4;

    logic              clk;
    logic              rst_n;
    logic              ex_valid;
    logic [DATA_W-1:0] ex_alu_result;
    logic [DATA_W-1:0] ex_store_data;
    logic [4:0]        ex_dst;
    logic              ex_reg_write;
    logic              ex_mem_read;
    logic              ex_mem_write;
    logic              stall;
    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_wb_data;
    logic [4:0]        mem_wb_dst;
    logic              mem_wb_we;
    logic              mem_err;

    mem_wb_stage #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid),
        .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
        .ex_dst(ex_dst), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .mem_wb_data(mem_wb_data),
        .mem_wb_dst(mem_wb_dst), .mem_wb_we(mem_wb_we), .mem_err(mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic        rw;
        logic        rd;
        logic        wr;
        logic [4:0]  dst;
        logic [31:0] alu;
        logic [31:0] sdata;
    } instr_t;

    int checks   = 0;
    int failures = 0;

    // Model: the instruction sitting in the MEM slot and the expected WB contents
    instr_t      cur;
    int          waited;
    int          tgt;
    bit          hold;
    logic        err_exp;
    logic        wb_we_e;
    logic [4:0]  wb_dst_e;
    logic [31:0] wb_data_e;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_stall"}, 32'(stall), 32'd0);
        check({tag, "_req"}, 32'(mem_req), 32'd0);
        check({tag, "_we"}, 32'(mem_we), 32'd0);
        check({tag, "_err"}, 32'(mem_err), 32'd0);
        check({tag, "_wbwe"}, 32'(mem_wb_we), 32'd0);
        check({tag, "_wbdst"}, 32'(mem_wb_dst), 32'd0);
        check({tag, "_wbdata"}, mem_wb_data, 32'd0);
    endtask

    task automatic model_reset();
        cur       = '0;
        waited    = 0;
        tgt       = 0;
        hold      = 1'b0;
        err_exp   = 1'b0;
        wb_we_e   = 1'b0;
        wb_dst_e  = 5'd0;
        wb_data_e = 32'd0;
    endtask

    function automatic instr_t mk(input logic rw, input logic rd, input logic wr,
                                  input logic [4:0] dst, input logic [31:0] alu,
                                  input logic [31:0] sdata);
        instr_t t;
        t.valid = 1'b1;
        t.rw    = rw;
        t.rd    = rd;
        t.wr    = wr;
        t.dst   = dst;
        t.alu   = alu;
        t.sdata = sdata;
        return t;
    endfunction

    function automatic instr_t rand_instr();
        logic [4:0] d;
        d = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return mk(1'($urandom_range(0, 3) != 0), 1'b0, 1'b0, d, $urandom, $urandom);
            2:       return mk(1'b1, 1'b1, 1'b0, d, $urandom, $urandom);
            default: return mk(1'b0, 1'b0, 1'b1, d, $urandom, $urandom);
        endcase
    endfunction

    // One clock cycle: drive at negedge, check handshake, clock, check WB
    task automatic cycle(input instr_t offer, input logic rdy, input logic [31:0] rdata);
        logic mem_op;
        logic stall_e;
        logic abort_e;
        ex_valid      = offer.valid;
        ex_alu_result = offer.alu;
        ex_store_data = offer.sdata;
        ex_dst        = offer.dst;
        ex_reg_write  = offer.rw;
        ex_mem_read   = offer.rd;
        ex_mem_write  = offer.wr;
        mem_ready     = rdy;
        mem_rdata     = rdata;
        #1;
        mem_op  = cur.valid && (cur.rd || cur.wr);
        stall_e = mem_op && !rdy;
        abort_e = stall_e && (waited == TIMEOUT - 1);
        check("stall", 32'(stall), 32'(stall_e));
        check("mem_req", 32'(mem_req), 32'(mem_op));
        check("mem_we", 32'(mem_we), 32'(mem_op && cur.wr));
        if (mem_op) begin
            check("mem_addr", mem_addr, cur.alu & ~32'h3);
            check("mem_wdata", mem_wdata, cur.sdata);
        end
        @(posedge clk);
        hold = stall_e;
        if (abort_e) begin
            err_exp   = 1'b1;
            cur       = '0;
            waited    = 0;
            wb_we_e   = 1'b0;
            wb_dst_e  = 5'd0;
            wb_data_e = 32'd0;
        end else if (!stall_e) begin
            wb_we_e   = cur.valid && cur.rw && !cur.wr && (cur.dst != 5'd0);
            wb_dst_e  = wb_we_e ? cur.dst : 5'd0;
            wb_data_e = !wb_we_e ? 32'd0 : (cur.rd ? rdata : cur.alu);
            cur       = offer.valid ? offer : '0;
            waited    = 0;
            tgt       = ($urandom_range(0, 7) == 0) ? TIMEOUT : int'($urandom_range(0, TIMEOUT - 1));
        end else begin
            waited++;
        end
        @(negedge clk);
        check("wb_we", 32'(mem_wb_we), 32'(wb_we_e));
        check("wb_dst", 32'(mem_wb_dst), 32'(wb_dst_e));
        check("wb_data", mem_wb_data, wb_data_e);
        check("mem_err", 32'(mem_err), 32'(err_exp));
    endtask

    initial begin
        instr_t      bub;
        instr_t      offer;
        logic        rdy;
        int          stall_cycles;
        bub           = '0;
        offer         = '0;
        rst_n         = 1'b0;
        ex_valid      = 1'b0;
        ex_alu_result = '0;
        ex_store_data = '0;
        ex_dst        = '0;
        ex_reg_write  = 1'b0;
        ex_mem_read   = 1'b0;
        ex_mem_write  = 1'b0;
        mem_rdata     = '0;
        mem_ready     = 1'b0;
        model_reset();

        // Reset state before any clock edge
        #1;
        check_quiet("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // ALU op, dst 5
        cycle(mk(1'b1, 1'b0, 1'b0, 5'd5, 32'h1234, 32'h0), 1'b0, 32'h0);
        cycle(bub, 1'b0, 32'h0);
        check("alu_we", 32'(mem_wb_we), 32'd1);
        check("alu_dst", 32'(mem_wb_dst), 32'd5);
        check("alu_data", mem_wb_data, 32'h1234);

        // Load from unaligned 0x103, two wait cycles
        stall_cycles = 0;
        cycle(mk(1'b1, 1'b1, 1'b0, 5'd7, 32'h103, 32'h0), 1'b0, 32'h0);
        check("ld_addr", mem_addr, 32'h100);
        for (int i = 0; i < 3; i++) begin
            cycle(bub, 1'(i == 2), 32'hCAFEF00D);
            if (hold) stall_cycles++;
        end
        check("ld_stalls", 32'(stall_cycles), 32'd2);
        check("ld_we", 32'(mem_wb_we), 32'd1);
        check("ld_dst", 32'(mem_wb_dst), 32'd7);
        check("ld_data", mem_wb_data, 32'hCAFEF00D);

        // Zero-wait store
        cycle(mk(1'b0, 1'b0, 1'b1, 5'd3, 32'h40, 32'h55), 1'b0, 32'h0);
        check("st_req", 32'(mem_req), 32'd1);
        check("st_memwe", 32'(mem_we), 32'd1);
        cycle(bub, 1'b1, 32'h0);
        check("st_wbwe", 32'(mem_wb_we), 32'd0);
        check("st_wbdst", 32'(mem_wb_dst), 32'd0);
        check("st_wbdata", mem_wb_data, 32'd0);
        check("st_req_done", 32'(mem_req), 32'd0);

        // Write to r0 is suppressed
        cycle(mk(1'b1, 1'b0, 1'b0, 5'd0, 32'hFFFF, 32'h0), 1'b1, 32'h0);
        cycle(bub, 1'b0, 32'h0);
        check("r0_we", 32'(mem_wb_we), 32'd0);
        check("r0_dst", 32'(mem_wb_dst), 32'd0);
        check("r0_data", mem_wb_data, 32'd0);

        // Load that never completes: timeout, then a normal ALU op
        stall_cycles = 0;
        cycle(mk(1'b1, 1'b1, 1'b0, 5'd9, 32'h200, 32'h0), 1'b0, 32'h0);
        for (int i = 0; i < TIMEOUT; i++) begin
            cycle(bub, 1'b0, 32'h0BAD);
            if (hold) stall_cycles++;
        end
        check("to_stalls", 32'(stall_cycles), 32'(TIMEOUT));
        check("to_err", 32'(mem_err), 32'd1);
        check("to_stall_low", 32'(stall), 32'd0);
        check("to_wbwe", 32'(mem_wb_we), 32'd0);
        cycle(mk(1'b1, 1'b0, 1'b0, 5'd12, 32'hA5A5, 32'h0), 1'b0, 32'h0);
        cycle(bub, 1'b0, 32'h0);
        check("post_to_data", mem_wb_data, 32'hA5A5);
        check("post_to_err", 32'(mem_err), 32'd1);

        // Asynchronous reset in the middle of a stalled load
        cycle(mk(1'b1, 1'b1, 1'b0, 5'd4, 32'h300, 32'h0), 1'b0, 32'h0);
        cycle(bub, 1'b0, 32'h0);
        check("pre_rst_stall", 32'(stall), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_quiet("rst_mid");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        cycle(bub, 1'b1, 32'hDEADBEEF);
        check("late_rdy_we", 32'(mem_wb_we), 32'd0);
        check("late_rdy_req", 32'(mem_req), 32'd0);

        // Random instruction stream with random memory latency
        for (int i = 0; i < 400; i++) begin
            if (!hold) offer = rand_instr();
            if (cur.valid && (cur.rd || cur.wr)) rdy = 1'(waited == tgt);
            else rdy = 1'($urandom_range(0, 1));
            cycle(offer, rdy, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
